ay_noise_lfsr: RTL and testbench
================================

# ay_noise_lfsr

Parametrised noise generator for the AY-3-891x sound core. Divides the `ay_clk` enable by a fixed prescaler, then by a programmable noise period, and steps a configurable Fibonacci LFSR on each terminal count. `out` feeds the channel mixers. Defaults reproduce the AY 17-bit noise shift register.

## Interface
- `PERIOD_BITS`, 5: width of `period`.
- `PRESCALE`, 16: `ay_clk` pulses per period-counter tick; must be ≥1.
- `LFSR_BITS`, 17: shift register width; must be ≥2.
- `TAPS`, 17'h00009: feedback mask, `LFSR_BITS` wide; feedback bit = XOR-reduce of (lfsr & TAPS).
- `INIT`, 17'h00001: reset and lock-up recovery value; must be nonzero.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ay_clk`  in  1  single-`clk`-wide enable pulse, synchronous to `clk`.
- `period`  in  `PERIOD_BITS`  noise period; 0 is treated as 1; sampled continuously.
- `out`  out  1  noise output, equal to lfsr[0].
- `step`  out  1  one-`clk` pulse on the edge where the LFSR shifts.
- `seed_load`  in  1  load strike (only with `AY_NOISE_SEED_EN`).
- `seed`  in  `LFSR_BITS`  seed value (only with `AY_NOISE_SEED_EN`).

## Operation
- **Prescaler:** `pre_cnt` has width clog2(`PRESCALE`), minimum 1.
  - On `ay_clk`, it increments.
  - At `PRESCALE`-1 with `ay_clk`, it wraps to 0 and raises internal `pre_tick`.
  - `PRESCALE`=1 means `pre_tick` = `ay_clk`.
- **Period counter:** `per_cnt` is `PERIOD_BITS` wide. `eff` = (`period`==0) ? 1 : `period`.
  - On `pre_tick`, if `per_cnt` ≥ `eff`-1, then `per_cnt` ← 0 and the LFSR steps.
  - Otherwise `per_cnt` increments.
  - The compare is ≥, not ==. If `period` is lowered below the current count, the next `pre_tick` terminates immediately; there is no wrap through 2^`PERIOD_BITS`.
- **LFSR step:**
  - fb = ^(lfsr & `TAPS`).
  - lfsr ← {fb, lfsr[`LFSR_BITS`-1:1]}.
  - If the result is all-zero, load `INIT` instead (lock-up guard).
- `out` is lfsr[0], taken straight from the register. It has no combinational path from inputs.
- `step` is registered. It is 1 for exactly the `clk` cycle following the shifting edge, aligned with the new `out`.
- With no `ay_clk` pulses, all state holds.

## Timing
- **Reset values:** `pre_cnt`=0, `per_cnt`=0, lfsr=`INIT`, `out`=`INIT`[0], `step`=0.
- **Reset timing:** reset acts immediately (asynchronous). Deassertion is expected synchronous to `clk`.
- **Reset mid-count:** discards all progress. No `step` pulse may occur while `reset` is high.
- **Step spacing:** `PRESCALE`×`eff` `ay_clk` pulses, counted in pulses, not `clk` cycles.
- **First step after reset:** on the `clk` edge of the (`PRESCALE`×`eff`)th `ay_clk` pulse. `out` and `step` change on that same edge.
- **Period changes:** take effect at the next `pre_tick` compare. There is no glitch and no restart of `pre_cnt`.
- **Back-to-back `ay_clk`** (every `clk`) is legal and must be counted exactly.

## Configuration
- `AY_NOISE_SEED_EN` defined:
  - Adds the `seed_load` and `seed` ports.
  - When `seed_load`=1 at a `clk` edge:
    - lfsr ← `seed`, or `INIT` if `seed`==0.
    - `pre_cnt` ← 0 and `per_cnt` ← 0.
    - `step` ← 0.
  - `seed_load` has priority over a simultaneous terminal count; that step is lost.
- `AY_NOISE_SEED_EN` undefined: the ports are absent and the LFSR is only ever `INIT` or a stepped value.

## Test plan
- **Defaults, `period`=1, `ay_clk` every `clk`:**
  - first `step` 16 clks after reset;
  - lfsr 0x00001→0x10000→0x08000→0x04000;
  - `out` 1→0→0→0;
  - `step` spacing exactly 16.
- **Period 0 vs 31:**
  - `period`=0 gives `step` spacing 16 `ay_clk` pulses, identical to `period`=1;
  - `period`=31 gives spacing 496.
- **Sparse enable:** `ay_clk` every 3rd `clk`, `period`=2 → `step` every 96 clks; no state change on non-`ay_clk` cycles.
- **Period drop:** `period`=31, wait until `per_cnt`=10, set `period`=2 → `step` on the very next `pre_tick`, then spacing 32 `ay_clk`.
- **Reset mid-count:** assert `reset` 5 `ay_clk` before a step → `out`=1, `step`=0 immediately; next step a full 16×`eff` `ay_clk` after release.
- **`AY_NOISE_SEED_EN`:**
  - `seed`=0x00000 → lfsr 0x00001;
  - `seed`=0x00008 → next step gives 0x10004;
  - `seed_load` coincident with a terminal count → no `step`, counters 0.

Source files
------------

// File: rtl/ay_noise_lfsr.sv
// AY noise: ay_clk prescaler -> period divider -> Fibonacci LFSR; out/step registered, no backpressure.
// Defining AY_NOISE_SEED_EN adds seed_load/seed for a synchronous reseed.
module ay_noise_lfsr #(
    parameter int                   PERIOD_BITS = 5,
    parameter int                   PRESCALE    = 16,
    parameter int                   LFSR_BITS   = 17,
    parameter logic [LFSR_BITS-1:0] TAPS        = 17'h00009,
    parameter logic [LFSR_BITS-1:0] INIT        = 17'h00001
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ay_clk,
    input  logic [PERIOD_BITS-1:0] period,
`ifdef AY_NOISE_SEED_EN
    input  logic                   seed_load,
    input  logic [LFSR_BITS-1:0]   seed,
`endif
    output logic                   out,
    output logic                   step
);

    localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0]       pre_cnt_q, pre_cnt_d;
    logic [PERIOD_BITS-1:0] per_cnt_q, per_cnt_d;
    logic [LFSR_BITS-1:0]   lfsr_q, lfsr_d;
    logic                   step_q, step_d;

    logic                   pre_tick;
    logic                   term;
    logic [PERIOD_BITS-1:0] eff_m1;
    logic                   fb;
    logic [LFSR_BITS-1:0]   lfsr_shift;

    always_comb begin
        pre_tick   = ay_clk && (pre_cnt_q == PRE_LAST);
        eff_m1     = (period == '0) ? '0 : period - PERIOD_BITS'(1);
        // >= rather than == so a lowered period terminates at once instead of wrapping
        term       = pre_tick && (per_cnt_q >= eff_m1);
        fb         = ^(lfsr_q & TAPS);
        lfsr_shift = {fb, lfsr_q[LFSR_BITS-1:1]};

        pre_cnt_d = pre_cnt_q;
        per_cnt_d = per_cnt_q;
        lfsr_d    = lfsr_q;
        step_d    = 1'b0;

        if (ay_clk) begin
            pre_cnt_d = pre_tick ? '0 : pre_cnt_q + PRE_W'(1);
        end
        if (pre_tick) begin
            per_cnt_d = term ? '0 : per_cnt_q + PERIOD_BITS'(1);
        end
        if (term) begin
            lfsr_d = (lfsr_shift == '0) ? INIT : lfsr_shift;
            step_d = 1'b1;
        end
`ifdef AY_NOISE_SEED_EN
        if (seed_load) begin
            lfsr_d    = (seed == '0) ? INIT : seed;
            pre_cnt_d = '0;
            per_cnt_d = '0;
            step_d    = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_cnt_q <= '0;
            per_cnt_q <= '0;
            lfsr_q    <= INIT;
            step_q    <= 1'b0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
            per_cnt_q <= per_cnt_d;
            lfsr_q    <= lfsr_d;
            step_q    <= step_d;
        end
    end

    assign out  = lfsr_q[0];
    assign step = step_q;

endmodule

// File: tb/tb_ay_noise_lfsr.sv
// Scoreboard bench for ay_noise_lfsr: the stimulus side predicts step edges and LFSR values,
// a monitor process pops and compares them whenever step is presented.
module tb_ay_noise_lfsr;
    localparam int          PB   = 5;
    localparam int          PRE  = 16;
    localparam int          LB   = 17;
    localparam logic [16:0] TAPS = 17'h00009;
    localparam logic [16:0] INIT = 17'h00001;

    logic          clk    = 1'b0;
    logic          reset  = 1'b1;
    logic          ay_clk = 1'b0;
    logic [PB-1:0] period = 5'd1;
    logic          out;
    logic          step;
`ifdef AY_NOISE_SEED_EN
    logic          seed_load = 1'b0;
    logic [LB-1:0] seed      = '0;
`endif

    ay_noise_lfsr dut (
        .clk      (clk),
        .reset    (reset),
        .ay_clk   (ay_clk),
        .period   (period),
`ifdef AY_NOISE_SEED_EN
        .seed_load(seed_load),
        .seed     (seed),
`endif
        .out      (out),
        .step     (step)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned e;
        logic [16:0] v;
    } exp_t;

    exp_t          exp_q[$];
    int unsigned   act_e[$];
    logic [16:0]   act_v[$];
    int unsigned   edge_n = 0;
    int unsigned   last_edge = 0;
    int            checks = 0;
    int            errors = 0;

    // reference model state: value after the upcoming edge
    logic [16:0]   m_lfsr = INIT;
    int            m_pre  = 0;
    int            m_per  = 0;
    int            per_req = 1;
    exp_t          mon_ex;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic logic [16:0] lfsr_next(input logic [16:0] v);
        logic [16:0] n;
        int          par;
        par = $countones(v & TAPS) % 2;
        n   = (v >> 1) | (17'(par) << 16);
        return (n == 0) ? INIT : n;
    endfunction

    function automatic int unsigned spacing();
        if (act_e.size() < 2) return 0;
        return act_e[act_e.size()-1] - act_e[act_e.size()-2];
    endfunction

    // One clk cycle of stimulus; the model predicts what the following edge does.
    task automatic drive(input logic a, input logic sl, input logic [16:0] sv);
        int eff;
        @(negedge clk);
        ay_clk = a;
        period = PB'(per_req);
`ifdef AY_NOISE_SEED_EN
        seed_load = sl;
        seed      = sv;
`endif
        last_edge = edge_n + 1;
        if (sl) begin
            m_lfsr = (sv == 0) ? INIT : sv;
            m_pre  = 0;
            m_per  = 0;
        end else if (a) begin
            m_pre++;
            if (m_pre == PRE) begin
                m_pre = 0;
                eff   = (per_req == 0) ? 1 : per_req;
                if (m_per + 1 >= eff) begin
                    m_per  = 0;
                    m_lfsr = lfsr_next(m_lfsr);
                    exp_q.push_back('{last_edge, m_lfsr});
                end else begin
                    m_per++;
                end
            end
        end
    endtask

    task automatic settle();
        drive(1'b0, 1'b0, 17'h0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        ay_clk = 1'b0;
`ifdef AY_NOISE_SEED_EN
        seed_load = 1'b0;
`endif
        m_lfsr = INIT;
        m_pre  = 0;
        m_per  = 0;
        exp_q.delete();
        #1;
        check("rst_out", out, INIT[0]);
        check("rst_step", step, 0);
        check("rst_lfsr", dut.lfsr_q, INIT);
        check("rst_per_cnt", dut.per_cnt_q, 0);
        check("rst_pre_cnt", dut.pre_cnt_q, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clear_act();
        act_e.delete();
        act_v.delete();
    endtask

    // monitor
    initial forever begin
        @(posedge clk);
        #1;
        check("lfsr_track", dut.lfsr_q, m_lfsr);
        check("out_track", out, m_lfsr[0]);
        if (step) begin
            act_e.push_back(edge_n);
            act_v.push_back(dut.lfsr_q);
            if (exp_q.size() == 0) begin
                check("unexpected_step", 1, 0);
            end else begin
                mon_ex = exp_q.pop_front();
                check("step_edge", edge_n, mon_ex.e);
                check("step_lfsr", dut.lfsr_q, mon_ex.v);
                check("step_out", out, mon_ex.v[0]);
            end
        end else if (exp_q.size() != 0 && exp_q[0].e <= edge_n) begin
            mon_ex = exp_q.pop_front();
            check("missed_step", 0, 1);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned first;
        int          n;
        int          r;

        do_reset();

        // defaults, period 1, back-to-back ay_clk
        per_req = 1;
        clear_act();
        drive(1'b1, 1'b0, 17'h0);
        first = last_edge;
        repeat (47) drive(1'b1, 1'b0, 17'h0);
        settle();
        check("s1_step_count", act_e.size(), 3);
        if (act_e.size() >= 3) begin
            check("s1_first_step_edge", act_e[0], first + 15);
            check("s1_spacing_a", act_e[1] - act_e[0], 16);
            check("s1_spacing_b", act_e[2] - act_e[1], 16);
            check("s1_lfsr_0", act_v[0], 17'h10000);
            check("s1_lfsr_1", act_v[1], 17'h08000);
            check("s1_lfsr_2", act_v[2], 17'h04000);
        end

        // period 0 behaves as 1
        per_req = 0;
        clear_act();
        repeat (40) drive(1'b1, 1'b0, 17'h0);
        settle();
        check("p0_spacing", spacing(), 16);

        // period 31
        per_req = 31;
        clear_act();
        repeat (1000) drive(1'b1, 1'b0, 17'h0);
        settle();
        check("p31_spacing", spacing(), 496);

        // sparse enable: every third clk, period 2
        per_req = 2;
        clear_act();
        repeat (100) begin
            drive(1'b1, 1'b0, 17'h0);
            drive(1'b0, 1'b0, 17'h0);
            drive(1'b0, 1'b0, 17'h0);
        end
        settle();
        check("sparse_spacing", spacing(), 96);

        // period drop from 31 to 2 at per_cnt 10
        do_reset();
        per_req = 31;
        n = 0;
        while (!(m_per == 10 && m_pre == 0) && n < 2000) begin
            drive(1'b1, 1'b0, 17'h0);
            n++;
        end
        settle();
        check("drop_per_cnt", dut.per_cnt_q, 10);
        per_req = 2;
        clear_act();
        repeat (16) drive(1'b1, 1'b0, 17'h0);
        first = last_edge;
        repeat (32) drive(1'b1, 1'b0, 17'h0);
        settle();
        check("drop_step_count", act_e.size(), 2);
        if (act_e.size() >= 2) begin
            check("drop_first_step", act_e[0], first);
            check("drop_spacing", act_e[1] - act_e[0], 32);
        end

        // reset five pulses before a step
        do_reset();
        per_req = 1;
        repeat (16) drive(1'b1, 1'b0, 17'h0);
        repeat (11) drive(1'b1, 1'b0, 17'h0);
        do_reset();
        clear_act();
        drive(1'b1, 1'b0, 17'h0);
        first = last_edge;
        repeat (15) drive(1'b1, 1'b0, 17'h0);
        settle();
        check("rst_mid_step_count", act_e.size(), 1);
        if (act_e.size() >= 1) check("rst_mid_step_edge", act_e[0], first + 15);

`ifdef AY_NOISE_SEED_EN
        do_reset();
        per_req = 1;
        drive(1'b0, 1'b1, 17'h00000);
        settle();
        check("seed_zero", dut.lfsr_q, 17'h00001);
        drive(1'b0, 1'b1, 17'h00008);
        settle();
        check("seed_8", dut.lfsr_q, 17'h00008);
        clear_act();
        repeat (16) drive(1'b1, 1'b0, 17'h0);
        settle();
        check("seed_8_step_count", act_e.size(), 1);
        if (act_e.size() >= 1) check("seed_8_step", act_v[0], 17'h10004);
        n = 0;
        while (m_pre != PRE - 1 && n < 100) begin
            drive(1'b1, 1'b0, 17'h0);
            n++;
        end
        drive(1'b1, 1'b1, 17'h00155);
        settle();
        check("seed_coinc_step", step, 0);
        check("seed_coinc_per", dut.per_cnt_q, 0);
        check("seed_coinc_pre", dut.pre_cnt_q, 0);
        check("seed_coinc_lfsr", dut.lfsr_q, 17'h00155);
`endif

        // randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 199));
            if (r < 6) per_req = int'($urandom_range(0, 3));
            if (r == 100) begin
                do_reset();
`ifdef AY_NOISE_SEED_EN
            end else if (r == 101) begin
                drive(1'($urandom_range(0, 1)), 1'b1, 17'($urandom_range(0, 3)));
`endif
            end else begin
                drive(1'($urandom_range(0, 1)), 1'b0, 17'h0);
            end
        end
        settle();
        settle();
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
